// File: rtl/requant_pkg.sv
// Shared constants and arithmetic helpers for the requantisation pipe.
// Helpers model the TFLite int8 rounding primitives bit-exactly.
package requant_pkg;

  localparam int ACC_W = 32;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  // round half away from zero on a right shift
  function automatic logic signed [31:0] rdbpot(
    input logic signed [31:0] y,
    input logic [4:0]         rsh
  );
    logic [31:0] mask;
    logic [31:0] rem;
    logic [31:0] thr;
    mask = (32'd1 << rsh) - 32'd1;
    rem  = y & mask;
    thr  = (mask >> 1) + {31'd0, y[31]};
    return (y >>> rsh) + ((rem > thr) ? 32'sd1 : 32'sd0);
  endfunction

  function automatic logic srdhm_sat_case(
    input logic signed [31:0] x,
    input logic signed [31:0] m
  );
    return (x == INT32_MIN) && (m == INT32_MIN);
  endfunction

endpackage

// File: rtl/requant_if.sv
// Valid/ready stream bundle between the requant pipe and its neighbours.
// The pipe itself sits on the slave side.
interface requant_if #(
  parameter int LANES   = 4,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
);

  logic                     in_valid;
  logic                     in_ready;
  logic [32*LANES-1:0]      in_acc;
  logic [32*LANES-1:0]      in_bias;
  logic [32*LANES-1:0]      in_mult;
  logic [SHIFT_W*LANES-1:0] in_shift;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W*LANES-1:0]   out_data;
  logic                     out_last;

  modport slave (
    input  in_valid,
    input  in_acc,
    input  in_bias,
    input  in_mult,
    input  in_shift,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    output in_acc,
    output in_bias,
    output in_mult,
    output in_shift,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/requant_lane.sv
// Five-stage requantisation datapath for a single lane.
// Each stage register loads only when its en bit is set.
module requant_lane
  import requant_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                en,
  input  logic signed [31:0]        acc,
  input  logic signed [31:0]        bias,
  input  logic signed [31:0]        mult,
  input  logic signed [SHIFT_W-1:0] shift,
  input  logic signed [31:0]        offset,
  input  logic signed [OUT_W-1:0]   act_min,
  input  logic signed [OUT_W-1:0]   act_max,
  output logic signed [OUT_W-1:0]   out
);

  logic signed [31:0]  s1_s;
  logic signed [31:0]  s1_m;
  logic [SHIFT_W-1:0]  s1_lsh;
  logic [4:0]          s1_rsh;

  logic signed [63:0]  s2_p;
  logic                s2_sat;
  logic [4:0]          s2_rsh;

  logic signed [31:0]  s3_y;
  logic [4:0]          s3_rsh;

  logic signed [31:0]  s4_z;

  logic signed [31:0]  d1_s;
  logic [SHIFT_W-1:0]  d1_lsh;
  logic [4:0]          d1_rsh;
  int                  neg;

  always_comb begin
    d1_s   = acc + bias;
    d1_lsh = '0;
    d1_rsh = '0;
    neg    = -int'(shift);
    if (shift[SHIFT_W-1]) begin
      d1_rsh = (neg > 31) ? 5'd31 : 5'(neg);
    end else begin
      d1_lsh = shift;
    end
  end

  logic signed [31:0] d2_x;
  logic signed [63:0] d2_xe;
  logic signed [63:0] d2_me;

  always_comb begin
    d2_x  = s1_s << s1_lsh;
    d2_xe = d2_x;
    d2_me = s1_m;
  end

  // truncating divide by 2^31: bias negatives up before the shift
  logic signed [63:0] d3_t;
  logic signed [63:0] d3_u;
  logic signed [31:0] d3_y;

  always_comb begin
    d3_t = s2_p + (s2_p[63] ? NUDGE_NEG : NUDGE_POS);
    d3_u = d3_t;
    if (d3_t[63]) begin
      d3_u = d3_t + 64'sd2147483647;
    end
    d3_y = s2_sat ? INT32_MAX : 32'(d3_u >>> 31);
  end

  logic signed [31:0] d4_z;

  always_comb begin
    d4_z = rdbpot(s3_y, s3_rsh) + offset;
  end

  // max applied last so it wins on an inverted range
  logic signed [31:0] lo;
  logic signed [31:0] hi;
  logic signed [31:0] c0;
  logic signed [31:0] c1;

  always_comb begin
    lo = act_min;
    hi = act_max;
    c0 = (s4_z < lo) ? lo : s4_z;
    c1 = (c0 > hi) ? hi : c0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_s   <= '0;
      s1_m   <= '0;
      s1_lsh <= '0;
      s1_rsh <= '0;
      s2_p   <= '0;
      s2_sat <= 1'b0;
      s2_rsh <= '0;
      s3_y   <= '0;
      s3_rsh <= '0;
      s4_z   <= '0;
      out    <= '0;
    end else begin
      if (en[0]) begin
        s1_s   <= d1_s;
        s1_m   <= mult;
        s1_lsh <= d1_lsh;
        s1_rsh <= d1_rsh;
      end
      if (en[1]) begin
        s2_p   <= d2_xe * d2_me;
        s2_sat <= srdhm_sat_case(d2_x, s1_m);
        s2_rsh <= s1_rsh;
      end
      if (en[2]) begin
        s3_y   <= d3_y;
        s3_rsh <= s2_rsh;
      end
      if (en[3]) begin
        s4_z <= d4_z;
      end
      if (en[4]) begin
        out <= c1[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// Multi-lane requantisation pipe: int32 accumulators to OUT_W activations.
// Lockstep 5-stage pipe; valid/last chain and backpressure live here.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  requant_if.slave                bus,
  input  logic signed [31:0]      out_offset,
  input  logic signed [OUT_W-1:0] act_min,
  input  logic signed [OUT_W-1:0] act_max
);

  logic [4:0] v;
  logic [4:0] l;
  logic [4:0] en;
  logic       adv;

  logic [LANES-1:0][OUT_W-1:0] lane_q;

  assign adv           = bus.out_ready | ~v[4];
  assign bus.in_ready  = adv;
  assign en            = {v[3:0], bus.in_valid} & {5{adv}};
  assign bus.out_valid = v[4];
  assign bus.out_last  = l[4];
  assign bus.out_data  = lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (adv) begin
      v <= {v[3:0], bus.in_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l <= '0;
    end else begin
      if (en[0]) begin
        l[0] <= bus.in_last;
      end
      for (int k = 1; k < 5; k++) begin
        if (en[k]) begin
          l[k] <= l[k-1];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .acc     (bus.in_acc[32*g +: 32]),
      .bias    (bus.in_bias[32*g +: 32]),
      .mult    (bus.in_mult[32*g +: 32]),
      .shift   (bus.in_shift[SHIFT_W*g +: SHIFT_W]),
      .offset  (out_offset),
      .act_min (act_min),
      .act_max (act_max),
      .out     (lane_q[g])
    );
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe: scaling, rounding, saturation,
// clamping, backpressure ordering and mid-stream reset.
module tb_requant_pipe;

  logic clk;
  logic rst;
  logic signed [31:0] out_offset;
  logic signed [7:0]  act_min;
  logic signed [7:0]  act_max;

  int n_cmp;
  int n_bad;

  requant_if #(.LANES(4), .OUT_W(8), .SHIFT_W(6)) bus ();

  requant_pipe #(
    .LANES   (4),
    .OUT_W   (8),
    .SHIFT_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .out_offset (out_offset),
    .act_min    (act_min),
    .act_max    (act_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_beat(
    input logic [127:0] a,
    input logic [127:0] b,
    input logic [127:0] m,
    input logic [23:0]  sh,
    input logic         lst,
    input logic [31:0]  e,
    input string        tag
  );
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_acc    = a;
    bus.in_bias   = b;
    bus.in_mult   = m;
    bus.in_shift  = sh;
    bus.in_last   = lst;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'd5);
    chk({tag, " data"}, 128'(bus.out_data), 128'(e));
    chk({tag, " last"}, 128'(bus.out_last), 128'(lst));
    @(posedge clk);
    #1;
    chk({tag, " drained"}, 128'(bus.out_valid), 128'd0);
  endtask

  logic [31:0] held_d;
  logic        held_l;
  logic [31:0] exp_d;
  logic        stalled;
  int          tx;
  int          rx;

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    out_offset    = -32'sd128;
    act_min       = -8'sd128;
    act_max       = 8'sd127;
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.in_bias   = '0;
    bus.in_mult   = '0;
    bus.in_shift  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst out_data", 128'(bus.out_data), 128'd0);
    chk("rst out_last", 128'(bus.out_last), 128'd0);
    chk("rst in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;

    // basic scaling, offset -128
    run_beat({32'd300, 32'd1000, 32'd0, 32'd100},
             {-32'sd100, 32'd200, 32'd0, 32'd0},
             {32'h7FFF_FFFF, {3{32'h4000_0000}}},
             {6'd0, 6'd0, 6'h3F, 6'h3F}, 1'b0,
             {8'd72, 8'd127, 8'h80, 8'h99}, "scale");

    @(negedge clk);
    out_offset = 32'sd0;

    // tie rounding, SRDHM saturation, clamp low
    run_beat({-32'sd1000, 32'h8000_0000, 32'd3, -32'sd3},
             '0,
             {32'h7FFF_FFFF, 32'h8000_0000,
              32'h7FFF_FFFF, 32'h7FFF_FFFF},
             {6'd0, 6'd0, 6'h3F, 6'h3F}, 1'b1,
             {8'h80, 8'h7F, 8'd2, 8'hFE}, "round_sat");

    // rsh clamp, bias wrap, sat then shift, left shift
    run_beat({-32'sd5, 32'h8000_0000,
              32'h7FFF_FFFF, 32'h7FFF_FFFF},
             {32'd0, 32'd0, 32'd1, 32'd0},
             {32'h4000_0000, 32'h8000_0000,
              32'h7FFF_FFFF, 32'h7FFF_FFFF},
             {6'd3, 6'h3F, 6'd0, 6'h20}, 1'b0,
             {8'hEC, 8'h7F, 8'h80, 8'h01}, "edges");

    @(negedge clk);
    out_offset = 32'sd5;

    // left shift wraps to zero, output is offset
    run_beat({32'd2, -32'sd7, 32'd7, 32'h4000_0000},
             '0,
             {32'h7FFF_FFFF, 32'h4000_0000,
              32'h4000_0000, 32'h7FFF_FFFF},
             {6'h3E, 6'd0, 6'd0, 6'd2}, 1'b0,
             {8'd6, 8'd2, 8'd9, 8'd5}, "lshift");

    @(negedge clk);
    out_offset = 32'sd0;
    act_min    = -8'sd10;
    act_max    = 8'sd20;

    run_beat({-32'sd10, 32'd15, -32'sd100, 32'd100},
             '0, {4{32'h7FFF_FFFF}}, '0, 1'b0,
             {8'hF6, 8'h0F, 8'hF6, 8'h14}, "clamp");

    @(negedge clk);
    act_min = 8'sd10;
    act_max = 8'sd5;

    run_beat({32'd7, 32'd0, 32'd100, -32'sd100},
             '0, {4{32'h7FFF_FFFF}}, '0, 1'b0,
             {4{8'd5}}, "inverted");

    @(negedge clk);
    act_min = -8'sd128;
    act_max = 8'sd127;

    // random backpressure stream
    tx      = 0;
    rx      = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    for (int cyc = 0; cyc < 400 && rx < 20; cyc++) begin
      @(negedge clk);
      bus.in_valid = (tx < 20);
      bus.in_bias  = '0;
      bus.in_mult  = {4{32'h7FFF_FFFF}};
      bus.in_shift = '0;
      bus.in_last  = (tx == 19);
      for (int i = 0; i < 4; i++) begin
        bus.in_acc[32*i +: 32] = 32'(tx * 4 + i - 40);
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        chk("stall valid", 128'(bus.out_valid), 128'd1);
        chk("stall data", 128'(bus.out_data), 128'(held_d));
        chk("stall last", 128'(bus.out_last), 128'(held_l));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          for (int i = 0; i < 4; i++) begin
            exp_d[8*i +: 8] = 8'(rx * 4 + i - 40);
          end
          chk("bp data", 128'(bus.out_data), 128'(exp_d));
          chk("bp last", 128'(bus.out_last),
              128'(rx == 19));
          rx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = bus.out_data;
          held_l  = bus.out_last;
        end
      end else begin
        stalled = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        tx++;
      end
    end
    chk("bp count", 128'(rx), 128'd20);

    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_last  = (k == 2);
      bus.in_acc   = {4{32'(k + 11)}};
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    chk("mid rst async", 128'(bus.out_valid), 128'd0);
    @(posedge clk);
    #1;
    chk("mid rst valid", 128'(bus.out_valid), 128'd0);
    chk("mid rst data", 128'(bus.out_data), 128'd0);
    chk("mid rst last", 128'(bus.out_last), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("post rst valid", 128'(bus.out_valid), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Parametrised, pipelined requantisation unit for the conv/FC datapath of the wav2letter accelerator.
- Converts LANES int32 accumulators per beat into OUT_W-bit activations: bias add, optional left shift, saturating rounding doubling high multiply, rounding divide by power of two, output offset, clamp.
- Generalises the team's combinational rounding-divide-by-POT to multi-lane, per-channel, signed-shift operation with a valid/ready stream interface.
- Bit-exact with the TFLite int8 reference kernels.

Parameters:
- LANES, 4, channels processed per beat.
- OUT_W, 8, output activation width, signed.
- SHIFT_W, 6, width of the signed per-lane shift field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_acc  in  32*LANES  signed accumulators; lane i at [32i+31:32i].
- in_bias  in  32*LANES  signed per-lane bias.
- in_mult  in  32*LANES  signed per-lane Q31 multiplier.
- in_shift  in  SHIFT_W*LANES  signed per-lane shift; >0 left, <=0 right by -shift.
- in_last  in  1  tag, carried with the beat.
- out_offset  in  32  signed output zero point; quasi-static.
- act_min  in  OUT_W  signed clamp low; quasi-static.
- act_max  in  OUT_W  signed clamp high; quasi-static.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W*LANES  signed results, same lane packing as the inputs.
- out_last  out  1  tag of the output beat.

Behaviour:
- Reset: all stage valids 0; out_valid=0, out_data=0, out_last=0.
- Pipeline: 5 registered stages; latency 5 cycles from accept to out_valid when unstalled.
- Handshake:
  - adv = out_ready | ~out_valid; in_ready = adv.
  - When adv is high, all stages shift by one; bubbles propagate but are not collapsed.
  - When adv is low, all stage registers hold, and out_data/out_last stay stable while out_valid is high.
  - Throughput is 1 beat/cycle with out_ready held high.
- S1: s = acc + bias, wrapping 32-bit. lsh = max(shift,0); rsh = max(-shift,0), clamped to 31.
- S2: x = s << lsh, wrapping 32-bit; p = x * mult as a 64-bit signed product.
- S3, SRDHM:
  - If x == mult == 0x80000000, result is 0x7FFFFFFF.
  - Else nudge = p>=0 ? 2^30 : 1-2^30; result = (p+nudge)/2^31, truncated toward zero.
- S4, rounding divide by POT of y by rsh:
  - mask = 2^rsh-1; rem = y & mask; thr = (mask>>1) + sign(y).
  - r = (y>>>rsh) + (rem>thr).
  - rsh=0 passes y unchanged.
  - Then z = r + out_offset, wrapping 32-bit.
- S5: out = clamp(z, act_min, act_max), truncated to OUT_W. act_min > act_max is illegal; act_max wins.
- Quasi-static inputs (out_offset, act_min, act_max) are not captured per beat. They may change only when the pipe is empty: no stage valid and no accepted beat in flight.
- Lanes are fully independent; no cross-lane saturation effects.
- Reset mid-stream: all in-flight beats are discarded immediately and no partial beat is emitted.
- A stage whose valid is 0 must not toggle its data registers. This is a power requirement; it is not checked.

Decomposition:
- Package requant_pkg:
  - ACC_W=32, INT32_MIN/INT32_MAX, NUDGE_POS/NUDGE_NEG constants.
  - Function rdbpot(y, rsh).
  - Function srdhm_sat_case(x, m).
- One sub-module, requant_lane: the S1–S5 datapath for one lane, taking adv as enable. Instantiated LANES times via generate.
- The valid/last shift chain and handshake stay in requant_pipe.

Test Plan:
- Basic scaling, lane 0: acc=100, bias=0, mult=0x40000000, shift=-1, offset=-128, clamp [-128,127] -> out=-103 at 5 cycles after accept.
- Negative tie rounding: acc=-3, mult=0x7FFFFFFF, shift=-1, offset=0 -> -2; same with acc=3 -> 2 (half away from zero).
- Saturation and clamp: acc=0x80000000, bias=0, mult=0x80000000, shift=0 -> SRDHM=0x7FFFFFFF, out=127; acc=-1000 with mult=0x7FFFFFFF -> out=-128.
- Left shift wraps: acc=0x40000000, shift=+2, mult=0x7FFFFFFF -> x=0, out=offset clamped (offset=5 -> 5).
- Backpressure: 20-beat stream with random out_ready (~50% duty) -> every beat emitted exactly once, in order. Lanes carry distinct values; in_last is set on beat 20 only and appears with beat 20. Outputs are stable while stalled.
- Reset: assert rst with 3 beats in flight -> out_valid=0 on the next edge and stays 0; no stale beat appears after rst deasserts.
